// File: rtl/mode_seq_pkg.sv
// -----------------------------------------------------------------------------
// mode_seq_pkg
// Shared types for the debug/test mode sequencer.
//   mode_state_e  : sequencer FSM states (encoding is visible on state_o)
//   mode_target_e : which mode a GUARD_IN interval is heading for
//   STATE_W       : width of the state encoding
// -----------------------------------------------------------------------------
package mode_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        NORMAL    = 3'd0,
        GUARD_IN  = 3'd1,
        DEBUG     = 3'd2,
        TEST      = 3'd3,
        GUARD_OUT = 3'd4
    } mode_state_e;

    typedef enum logic {
        TGT_DEBUG = 1'b0,
        TGT_TEST  = 1'b1
    } mode_target_e;

endpackage

// File: rtl/mode_guard_timer.sv
// -----------------------------------------------------------------------------
// mode_guard_timer
// Loadable down-counter that times both guard intervals of the sequencer.
// The count saturates at zero; a load takes priority over counting.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset (count -> 0)
//   load_i      load load_val_i on the next edge
//   load_val_i  value to load
//   value_o     current count
//   done_o      high while the count is zero
// -----------------------------------------------------------------------------
module mode_guard_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] value_o,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;
    assign done_o  = (count_q == '0);

endmodule

// File: rtl/mode_sequencer.sv
// -----------------------------------------------------------------------------
// mode_sequencer
// Grants the mutually exclusive debug and test modes. Every entry and exit
// passes through a guard interval of GUARD_CYCLES cycles; test-mode residency
// is bounded by TEST_TIMEOUT cycles (0 disables the bound). After a timeout,
// test entry is locked out until test_req has been low for at least a cycle.
//
// Parameters:
//   GUARD_CYCLES  cycles per guard state (1..15)
//   TEST_TIMEOUT  max consecutive test_mode cycles, 0 = unbounded (0..255)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   debug_req   level request for debug mode
//   test_req    level request for test mode
//   debug_mode  debug mode granted (state == DEBUG)
//   test_mode   test mode granted (state == TEST)
//   mode_busy   state != NORMAL
//   timeout_o   one-cycle pulse: test mode ended by timeout
//   preempt_o   one-cycle pulse: test mode ended by debug_req
//   state_o     current state encoding
//
// Optional build macro: MODE_SEQ_ASSERT_EN compiles in concurrent properties
// checking mode exclusivity, test residency and guard length.
// -----------------------------------------------------------------------------
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int TEST_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               debug_req,
    input  logic               test_req,
    output logic               debug_mode,
    output logic               test_mode,
    output logic               mode_busy,
    output logic               timeout_o,
    output logic               preempt_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int GUARD_W = 4;
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

    // Residency counter only needs to reach TEST_TIMEOUT-1.
    localparam int RES_W = (TEST_TIMEOUT > 1) ? $clog2(TEST_TIMEOUT) : 1;
    localparam logic [RES_W-1:0] RES_LAST =
        RES_W'((TEST_TIMEOUT == 0) ? 0 : TEST_TIMEOUT - 1);

    mode_state_e      state_q, state_d;
    mode_target_e     target_q, target_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             lockout_q, lockout_d;

    logic debug_mode_q, test_mode_q, mode_busy_q;
    logic timeout_q, preempt_q;

    logic               guard_load;
    logic               guard_done;
    logic [GUARD_W-1:0] unused_guard_value;

    logic timeout_evt;
    logic preempt_evt;
    logic target_req;
    logic timeout_hit;

    mode_guard_timer #(
        .WIDTH (GUARD_W)
    ) u_guard_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (guard_load),
        .load_val_i (GUARD_LOAD),
        .value_o    (unused_guard_value),
        .done_o     (guard_done)
    );

    assign target_req  = (target_q == TGT_DEBUG) ? debug_req : test_req;
    assign timeout_hit = (TEST_TIMEOUT != 0) && (res_q == RES_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        res_d       = res_q;
        guard_load  = 1'b0;
        timeout_evt = 1'b0;
        preempt_evt = 1'b0;

        case (state_q)
            NORMAL: begin
                // Debug has priority; lockout blocks test entry only.
                if (debug_req) begin
                    state_d    = GUARD_IN;
                    target_d   = TGT_DEBUG;
                    guard_load = 1'b1;
                end else if (test_req && !lockout_q) begin
                    state_d    = GUARD_IN;
                    target_d   = TGT_TEST;
                    guard_load = 1'b1;
                end
            end

            GUARD_IN: begin
                // Abort beats completion: a dropped request never grants.
                if (!target_req) begin
                    state_d    = GUARD_OUT;
                    guard_load = 1'b1;
                end else if (guard_done) begin
                    state_d = (target_q == TGT_DEBUG) ? DEBUG : TEST;
                    res_d   = '0;
                end
            end

            DEBUG: begin
                if (!debug_req) begin
                    state_d    = GUARD_OUT;
                    guard_load = 1'b1;
                end
            end

            TEST: begin
                if (!test_req || debug_req || timeout_hit) begin
                    state_d     = GUARD_OUT;
                    guard_load  = 1'b1;
                    preempt_evt = debug_req;
                    timeout_evt = timeout_hit;
                end else if (res_q != '1) begin
                    res_d = res_q + 1'b1;
                end
            end

            GUARD_OUT: begin
                if (guard_done) begin
                    state_d = NORMAL;
                end
            end

            default: begin
                state_d = NORMAL;
            end
        endcase

        // A low test_req always releases the lockout, even on a timeout edge.
        lockout_d = test_req ? (lockout_q | timeout_evt) : 1'b0;
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NORMAL;
            target_q     <= TGT_DEBUG;
            res_q        <= '0;
            lockout_q    <= 1'b0;
            debug_mode_q <= 1'b0;
            test_mode_q  <= 1'b0;
            mode_busy_q  <= 1'b0;
            timeout_q    <= 1'b0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            res_q        <= res_d;
            lockout_q    <= lockout_d;
            debug_mode_q <= (state_d == DEBUG);
            test_mode_q  <= (state_d == TEST);
            mode_busy_q  <= (state_d != NORMAL);
            timeout_q    <= timeout_evt;
            preempt_q    <= preempt_evt;
        end
    end

    assign debug_mode = debug_mode_q;
    assign test_mode  = test_mode_q;
    assign mode_busy  = mode_busy_q;
    assign timeout_o  = timeout_q;
    assign preempt_o  = preempt_q;
    assign state_o    = state_q;

`ifdef MODE_SEQ_ASSERT_EN
    // Run-length trackers for the residency and guard-length properties.
    logic [3:0] sva_gin_run_q;
    logic [8:0] sva_test_run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sva_gin_run_q  <= '0;
            sva_test_run_q <= '0;
        end else begin
            if (state_q == GUARD_IN) begin
                if (sva_gin_run_q != '1) begin
                    sva_gin_run_q <= sva_gin_run_q + 4'd1;
                end
            end else begin
                sva_gin_run_q <= '0;
            end
            if (test_mode_q) begin
                if (sva_test_run_q != '1) begin
                    sva_test_run_q <= sva_test_run_q + 9'd1;
                end
            end else begin
                sva_test_run_q <= '0;
            end
        end
    end

    a_modes_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(debug_mode && test_mode))
        else $error("debug_mode and test_mode high together");

    a_test_residency: assert property (@(posedge clk) disable iff (rst)
        ((TEST_TIMEOUT != 0) && test_mode) |-> (sva_test_run_q < 9'(TEST_TIMEOUT)))
        else $error("test_mode exceeded TEST_TIMEOUT");

    a_guard_before_mode: assert property (@(posedge clk) disable iff (rst)
        $rose(debug_mode || test_mode) |-> (sva_gin_run_q == 4'(GUARD_CYCLES)))
        else $error("mode granted without a full GUARD_IN interval");

    r_no_test_at_reset_release: restrict property (@(posedge clk) disable iff (rst)
        $fell(rst) |-> !$rose(test_req));
`endif

endmodule

// File: tb/tb_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mode_sequencer
// Directed bench for mode_sequencer with a behavioural reference kept in terms
// of "phase / guard cycles remaining / test cycles spent". Every cycle the DUT
// outputs are compared against the reference; scenario-specific literal
// checks pin the reference itself.
// -----------------------------------------------------------------------------
module tb_mode_sequencer;

    localparam int G = 2;
    localparam int T = 16;

    // Spec-defined state encoding as seen on state_o.
    localparam int P_NORMAL = 0;
    localparam int P_GIN    = 1;
    localparam int P_DEBUG  = 2;
    localparam int P_TEST   = 3;
    localparam int P_GOUT   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       debug_req;
    logic       test_req;
    logic       debug_mode;
    logic       test_mode;
    logic       mode_busy;
    logic       timeout_o;
    logic       preempt_o;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    int cnt_test = 0;
    int cnt_dbg  = 0;
    int cnt_to   = 0;
    int cnt_pre  = 0;

    mode_sequencer #(
        .GUARD_CYCLES (G),
        .TEST_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_req  (debug_req),
        .test_req   (test_req),
        .debug_mode (debug_mode),
        .test_mode  (test_mode),
        .mode_busy  (mode_busy),
        .timeout_o  (timeout_o),
        .preempt_o  (preempt_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_st   = P_NORMAL;
    int m_left = 0;    // guard cycles still to spend, counting down to 1
    int m_age  = 0;    // number of cycles test_mode has been high so far
    bit m_tgt_test = 1'b0;
    bit m_lock = 1'b0;
    bit m_to   = 1'b0;
    bit m_pre  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = P_NORMAL; m_left = 0; m_age = 0;
            m_tgt_test = 1'b0; m_lock = 1'b0; m_to = 1'b0; m_pre = 1'b0;
        end else begin
            m_to  = 1'b0;
            m_pre = 1'b0;
            case (m_st)
                P_NORMAL: begin
                    if (debug_req) begin
                        m_st = P_GIN; m_tgt_test = 1'b0; m_left = G;
                    end else if (test_req && !m_lock) begin
                        m_st = P_GIN; m_tgt_test = 1'b1; m_left = G;
                    end
                end
                P_GIN: begin
                    if ((m_tgt_test ? test_req : debug_req) == 1'b0) begin
                        m_st = P_GOUT; m_left = G;
                    end else if (m_left == 1) begin
                        m_st  = m_tgt_test ? P_TEST : P_DEBUG;
                        m_age = 1;
                    end else begin
                        m_left = m_left - 1;
                    end
                end
                P_DEBUG: begin
                    if (!debug_req) begin
                        m_st = P_GOUT; m_left = G;
                    end
                end
                P_TEST: begin
                    if (!test_req || debug_req || (T != 0 && m_age == T)) begin
                        m_pre = debug_req;
                        m_to  = (T != 0 && m_age == T);
                        m_st  = P_GOUT; m_left = G;
                    end else begin
                        m_age = m_age + 1;
                    end
                end
                P_GOUT: begin
                    if (m_left == 1) m_st = P_NORMAL;
                    else m_left = m_left - 1;
                end
                default: m_st = P_NORMAL;
            endcase
            if (!test_req) m_lock = 1'b0;
            else if (m_to) m_lock = 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_tally();
        cnt_test = 0; cnt_dbg = 0; cnt_to = 0; cnt_pre = 0;
    endtask

    // Advance n cycles; after each edge compare every output with the model.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("model_state", int'(state_o), m_st);
            chk("model_outs",
                int'({debug_mode, test_mode, mode_busy, timeout_o, preempt_o}),
                int'({m_st == P_DEBUG, m_st == P_TEST, m_st != P_NORMAL, m_to, m_pre}));
            if (test_mode)  cnt_test++;
            if (debug_mode) cnt_dbg++;
            if (timeout_o)  cnt_to++;
            if (preempt_o)  cnt_pre++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; debug_req = 1'b0; test_req = 1'b0;
        #1 rst = 1'b1;
        step(2);
        chk("reset_state", int'(state_o), 0);
        chk("reset_outs", int'({debug_mode, test_mode, mode_busy, timeout_o, preempt_o}), 0);
        rst = 1'b0;
        step(1);
        $display("txn reset: state=%0d", state_o);

        // Debug entry/exit with guard timing.
        debug_req = 1'b1;
        step(1); chk("s1_gin_a", int'(state_o), 1);
        step(1); chk("s1_gin_b", int'(state_o), 1);
        step(1); chk("s1_dbg_on", int'(debug_mode), 1);
        debug_req = 1'b0;
        step(1); chk("s1_dbg_off", int'(debug_mode), 0); chk("s1_gout", int'(state_o), 4);
        step(1); chk("s1_gout_b", int'(state_o), 4);
        step(1); chk("s1_normal", int'(state_o), 0);
        $display("txn debug entry/exit: state=%0d", state_o);

        // Both requests together: debug wins.
        clear_tally();
        debug_req = 1'b1; test_req = 1'b1;
        step(3); chk("s2_dbg_on", int'(debug_mode), 1);
        step(3); chk("s2_no_test", cnt_test, 0);
        debug_req = 1'b0; test_req = 1'b0;
        step(4);
        $display("txn both requests: debug_cycles=%0d test_cycles=%0d", cnt_dbg, cnt_test);

        // Timeout and lockout.
        clear_tally();
        test_req = 1'b1;
        step(40);
        chk("s3_test_cycles", cnt_test, 16);
        chk("s3_timeout_pulses", cnt_to, 1);
        chk("s3_locked_normal", int'(state_o), 0);
        test_req = 1'b0;
        step(1);
        test_req = 1'b1;
        step(3); chk("s3_reentry", int'(test_mode), 1);
        test_req = 1'b0;
        step(4);
        $display("txn timeout: test_cycles=%0d timeouts=%0d", cnt_test, cnt_to);

        // Debug preempts test at TEST cycle 5.
        test_req = 1'b1;
        step(3); chk("s4_test_on", int'(test_mode), 1);
        step(4);
        clear_tally();
        debug_req = 1'b1;
        step(1);
        chk("s4_test_off", int'(test_mode), 0);
        chk("s4_preempt", int'(preempt_o), 1);
        chk("s4_gout", int'(state_o), 4);
        step(5); chk("s4_dbg_on", int'(debug_mode), 1);
        chk("s4_pre_pulses", cnt_pre, 1);
        chk("s4_no_timeout", cnt_to, 0);
        debug_req = 1'b0; test_req = 1'b0;
        step(4);
        $display("txn preempt: preempts=%0d", cnt_pre);

        // One-cycle test request aborts in GUARD_IN.
        clear_tally();
        test_req = 1'b1;
        step(1); chk("s5_gin", int'(state_o), 1);
        test_req = 1'b0;
        step(1); chk("s5_abort", int'(state_o), 4);
        step(4);
        chk("s5_no_test", cnt_test, 0);
        chk("s5_normal", int'(state_o), 0);
        $display("txn abort: test_cycles=%0d", cnt_test);

        // Asynchronous reset in the middle of DEBUG.
        debug_req = 1'b1;
        step(3); chk("s6_dbg_on", int'(debug_mode), 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_dbg", int'(debug_mode), 0);
        chk("s6_async_state", int'(state_o), 0);
        chk("s6_async_busy", int'(mode_busy), 0);
        debug_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(3); chk("s6_after", int'(state_o), 0);
        $display("txn async reset: state=%0d", state_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Controller that grants the mutually exclusive debug and test modes to the rest of the design.
- Accepts two level requests, debug_req and test_req.
- Inserts guard intervals on every mode entry and exit.
- Bounds test-mode residency with a timeout.
- Debug_mode and test_mode are never high together.

Parameters:
GUARD_CYCLES, 2, cycles spent in each guard state; legal range 1..15.
TEST_TIMEOUT, 16, maximum consecutive cycles test_mode may stay high; 0 disables the timeout; legal range 0..255.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
debug_req  input  1  level request for debug mode
test_req  input  1  level request for test mode
debug_mode  output  1  debug mode granted
test_mode  output  1  test mode granted
mode_busy  output  1  high in any state other than NORMAL
timeout_o  output  1  one-cycle pulse when test mode is forcibly ended by timeout
preempt_o  output  1  one-cycle pulse when test mode is ended by debug_req
state_o  output  3  current FSM state encoding

Behaviour:
- Interface (decided): one clock, clk; rst is asynchronous, active-high.
- While rst is high: state=NORMAL, all counters 0, lockout=0, every output 0.
- Outputs are registered and Moore-style:
  - debug_mode = (state==DEBUG)
  - test_mode = (state==TEST)
  - mode_busy = (state!=NORMAL)
- States: NORMAL, GUARD_IN, DEBUG, TEST, GUARD_OUT.
- NORMAL:
  - debug_req=1 → GUARD_IN, target=DEBUG.
  - Else test_req=1 and lockout=0 → GUARD_IN, target=TEST.
  - Debug wins when both are high.
  - Guard counter loads GUARD_CYCLES-1.
- GUARD_IN:
  - Counter decrements each cycle; at 0, next edge → target state.
  - GUARD_IN therefore lasts exactly GUARD_CYCLES cycles. Example: request sampled at edge k, mode output high after edge k+GUARD_CYCLES.
  - If the target's request drops during GUARD_IN → GUARD_OUT (abort); no mode output is asserted.
- DEBUG: stays while debug_req=1; test_req is ignored. debug_req=0 → GUARD_OUT.
- TEST:
  - Residency counter clears on entry and increments each cycle.
  - Exit to GUARD_OUT on the first of:
    - test_req=0
    - debug_req=1 (preempt_o pulses in the first GUARD_OUT cycle)
    - counter==TEST_TIMEOUT-1 with TEST_TIMEOUT≠0 (timeout_o pulses in the first GUARD_OUT cycle; lockout set)
  - Test_mode is high for at most TEST_TIMEOUT cycles.
  - If debug preempt and timeout coincide, preempt_o and timeout_o both pulse, and lockout is set.
- GUARD_OUT: lasts GUARD_CYCLES cycles, then → NORMAL. Requests are ignored during it.
- Lockout: set on timeout, cleared in any cycle where test_req=0. Blocks test entry only; debug is unaffected.
- After a preempt, debug_req still high in NORMAL → GUARD_IN(DEBUG).
- Reset mid-operation: immediate return to NORMAL with both modes low, independent of clk.
- Counters never wrap: the guard counter saturates at 0; the residency counter is sized to TEST_TIMEOUT and stops on exit.

Optional Feature:
- Macro MODE_SEQ_ASSERT_EN.
- When defined, the block contains concurrent properties, each @(posedge clk) disable iff (rst):
  - assert !(debug_mode && test_mode)
  - assert test_mode is never high for more than TEST_TIMEOUT consecutive cycles (TEST_TIMEOUT≠0)
  - assert a mode output rises only after GUARD_CYCLES cycles of GUARD_IN
  - restrict property: test_req never rises in the same cycle as rst falling
- When undefined: no properties are compiled; functional behaviour is identical.

Decomposition:
- Package mode_seq_pkg:
  - typedef enum logic [2:0] mode_state_e (NORMAL=0, GUARD_IN=1, DEBUG=2, TEST=3, GUARD_OUT=4)
  - typedef enum logic mode_target_e (TGT_DEBUG, TGT_TEST)
  - localparam STATE_W=3
- One sub-module, mode_guard_timer: loadable down-counter with load, value and done outputs. It implements both guard intervals.

Test Plan:
- Reset, then debug_req=1 at edge 0 (GUARD_CYCLES=2) → GUARD_IN edges 0–1, debug_mode=1 after edge 2; debug_req=0 → debug_mode=0 next edge, NORMAL 2 cycles later.
- debug_req and test_req rise together → debug granted, test_mode stays 0 throughout.
- test_req held high, TEST_TIMEOUT=16 → test_mode high exactly 16 cycles, timeout_o one pulse; no re-entry until test_req drops for ≥1 cycle.
- In TEST, raise debug_req at cycle 5 → test_mode falls next edge, preempt_o pulses; after GUARD_OUT then GUARD_IN, debug_mode=1.
- test_req pulses for 1 cycle in NORMAL → GUARD_IN then abort to GUARD_OUT; test_mode never asserts.
- Assert rst mid-DEBUG (asynchronous, between edges) → debug_mode=0, state_o=0 immediately; with MODE_SEQ_ASSERT_EN defined, no assertion fires across any scenario.
